// File: rtl/uart_stream_ctrl.sv
// uart_stream_ctrl -- streams a block of bytes from a synchronous-read byte
// memory into a uart_tx transmitter, one byte per Tx_Done handshake, and
// reports progress (byte count) and completion (Done pulse) to the host.
// Build macro UART_STREAM_CHECKSUM_EN appends an 8-bit running-sum byte
// after a completed (non-aborted) payload.
module uart_stream_ctrl #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    LEN_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
  input  logic                  abort_i,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [7:0]            mem_data_i,
  output logic                  tx_dv_o,
  output logic [7:0]            tx_byte_o,
  input  logic                  tx_active_i,
  input  logic                  tx_done_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [LEN_WIDTH-1:0]  byte_count_o
);

`ifdef UART_STREAM_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_FETCH, S_LOAD, S_SEND, S_WAIT, S_FIN, S_CSUM
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_FETCH, S_LOAD, S_SEND, S_WAIT, S_FIN
  } state_e;
`endif

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] idx_q, idx_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
`ifdef UART_STREAM_CHECKSUM_EN
  logic [7:0]           sum_q, sum_d;
  logic                 csum_q, csum_d;  // next/current byte is the checksum
`endif

  // State and datapath registers; uart_tx is never reset, so SYNC guards it.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      tx_byte_q <= '0;
`ifdef UART_STREAM_CHECKSUM_EN
      sum_q     <= '0;
      csum_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      tx_byte_q <= tx_byte_d;
`ifdef UART_STREAM_CHECKSUM_EN
      sum_q     <= sum_d;
      csum_q    <= csum_d;
`endif
    end
  end

  // Next-state and strobe decode for the fetch/launch/wait sequence.
  // NOTE: every variable gets a default first so no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    tx_byte_d   = tx_byte_q;
    mem_rd_en_o = 1'b0;
    mem_addr_o  = '0;
    tx_dv_o     = 1'b0;
    done_o      = 1'b0;
    busy_o      = (state_q != S_IDLE);
`ifdef UART_STREAM_CHECKSUM_EN
    sum_d       = sum_q;
    csum_d      = csum_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d = length_i;
          idx_d = '0;
          cnt_d = '0;
`ifdef UART_STREAM_CHECKSUM_EN
          sum_d   = '0;
          csum_d  = (length_i == '0);  // empty block sends only the sum
          state_d = S_SYNC;
`else
          state_d = (length_i == '0) ? S_FIN : S_SYNC;
`endif
        end
      end
      // A Tx_DV issued while uart_tx is active or in cleanup is lost.
      S_SYNC: begin
        if (!tx_active_i && !tx_done_i) begin
`ifdef UART_STREAM_CHECKSUM_EN
          state_d = csum_q ? S_CSUM : S_FETCH;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_FETCH: begin
        mem_rd_en_o = 1'b1;
        mem_addr_o  = BASE_ADDR + ADDR_WIDTH'(idx_q);
        state_d     = S_LOAD;
      end
      S_LOAD: begin
        tx_byte_d = mem_data_i;
`ifdef UART_STREAM_CHECKSUM_EN
        sum_d     = sum_q + mem_data_i;
`endif
        state_d   = S_SEND;
      end
`ifdef UART_STREAM_CHECKSUM_EN
      S_CSUM: begin
        tx_byte_d = sum_q;
        state_d   = S_SEND;
      end
`endif
      S_SEND: begin
        tx_dv_o = 1'b1;
        state_d = S_WAIT;
      end
      // Abort is only honoured here, so a launched byte always completes.
      S_WAIT: begin
        if (tx_done_i) begin
`ifdef UART_STREAM_CHECKSUM_EN
          if (csum_q) begin
            state_d = S_FIN;
          end else begin
            cnt_d = cnt_q + LEN_WIDTH'(1);
            idx_d = idx_q + LEN_WIDTH'(1);
            if (abort_i) begin
              state_d = S_FIN;
            end else if (idx_d == len_q) begin
              csum_d  = 1'b1;
              state_d = S_SYNC;
            end else begin
              state_d = S_SYNC;
            end
          end
`else
          cnt_d = cnt_q + LEN_WIDTH'(1);
          idx_d = idx_q + LEN_WIDTH'(1);
          if (abort_i || (idx_d == len_q)) state_d = S_FIN;
          else                             state_d = S_SYNC;
`endif
        end
      end
      S_FIN: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_byte_o    = tx_byte_q;
  assign byte_count_o = cnt_q;

endmodule
